lsu_ctrl: RTL

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: forwards AGU commands to the DTCM and tracks them in an
// in-order outstanding queue, so each response can be aligned, extended and tagged for write-back.
module lsu_ctrl #(
  parameter int XLEN            = 32,
  parameter int DTCM_ADDR_WIDTH = 16,
  parameter int ITAG_WIDTH      = 2,
  parameter int OUTS_DEPTH      = 2,
  localparam int PTR_W          = $clog2(OUTS_DEPTH),
  localparam int CNT_W          = PTR_W + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       agu_cmd_valid,
  output logic                       agu_cmd_ready,
  input  logic [DTCM_ADDR_WIDTH-1:0] agu_cmd_addr,
  input  logic                       agu_cmd_read,
  input  logic [XLEN-1:0]            agu_cmd_wdata,
  input  logic [XLEN/8-1:0]          agu_cmd_wmask,
  input  logic [ITAG_WIDTH-1:0]      agu_cmd_itag,
  input  logic                       agu_cmd_usign,
  input  logic [1:0]                 agu_cmd_size,
  output logic                       dtcm_cmd_valid,
  input  logic                       dtcm_cmd_ready,
  output logic [DTCM_ADDR_WIDTH-1:0] dtcm_cmd_addr,
  output logic                       dtcm_cmd_read,
  output logic [XLEN-1:0]            dtcm_cmd_wdata,
  output logic [XLEN/8-1:0]          dtcm_cmd_wmask,
  input  logic                       dtcm_rsp_valid,
  output logic                       dtcm_rsp_ready,
  input  logic [XLEN-1:0]            dtcm_rsp_rdata,
  input  logic                       dtcm_rsp_err,
  output logic                       lsu_o_valid,
  input  logic                       lsu_o_ready,
  output logic [XLEN-1:0]            lsu_o_wbck_wdat,
  output logic                       lsu_o_wbck_en,
  output logic [ITAG_WIDTH-1:0]      lsu_o_itag,
  output logic                       lsu_o_err,
  output logic                       lsu_o_misalgn,
  output logic                       lsu_busy,
  output logic [CNT_W-1:0]           lsu_outs_cnt
);

  localparam int ENT_W = ITAG_WIDTH + 7;

  logic [ENT_W-1:0] ent_mem_q [OUTS_DEPTH];
  logic [ENT_W-1:0] ent_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic                  cmd_misalgn, full, empty, push, pop;
  logic [ITAG_WIDTH-1:0] head_itag;
  logic                  head_usign, head_read, head_misalgn;
  logic [1:0]            head_size, head_off;

  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] rdata,
                                                  input logic [1:0] size,
                                                  input logic [1:0] off,
                                                  input logic usign);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{off, 3'b000} +: 8];
    h = rdata[{off[1], 4'b0000} +: 16];
    case (size)
      2'b00:   load_extend = {{(XLEN-8){b[7] & ~usign}}, b};
      2'b01:   load_extend = {{(XLEN-16){h[15] & ~usign}}, h};
      default: load_extend = rdata;
    endcase
  endfunction

  always_comb begin
    cmd_misalgn = ((agu_cmd_size == 2'b01) && agu_cmd_addr[0]) ||
                  ((agu_cmd_size == 2'b10) && (agu_cmd_addr[1:0] != 2'b00));
    full  = (cnt_q == CNT_W'(OUTS_DEPTH));
    empty = (cnt_q == '0);

    // A full queue blocks new commands even when the head retires this cycle.
    agu_cmd_ready  = ~full & (cmd_misalgn | dtcm_cmd_ready);
    dtcm_cmd_valid = agu_cmd_valid & ~full & ~cmd_misalgn;
    dtcm_cmd_addr  = agu_cmd_addr;
    dtcm_cmd_read  = agu_cmd_read;
    dtcm_cmd_wdata = agu_cmd_wdata;
    dtcm_cmd_wmask = agu_cmd_wmask;
    push  = agu_cmd_valid & agu_cmd_ready;
    ent_d = {agu_cmd_itag, agu_cmd_usign, agu_cmd_size, agu_cmd_addr[1:0],
             agu_cmd_read, cmd_misalgn};
  end

  always_comb begin
    {head_itag, head_usign, head_size, head_off, head_read, head_misalgn} = ent_mem_q[rd_ptr_q];

    // Misaligned heads retire on their own without consuming a DTCM response.
    lsu_o_valid     = ~empty & (head_misalgn | dtcm_rsp_valid);
    dtcm_rsp_ready  = lsu_o_ready & ~empty & ~head_misalgn;
    lsu_o_err       = dtcm_rsp_err | head_misalgn;
    lsu_o_misalgn   = head_misalgn;
    lsu_o_wbck_en   = head_read & ~lsu_o_err;
    lsu_o_itag      = head_itag;
    lsu_o_wbck_wdat = (head_read && !head_misalgn) ?
                      load_extend(dtcm_rsp_rdata, head_size, head_off, head_usign) : '0;
    pop      = lsu_o_valid & lsu_o_ready;
    lsu_busy     = ~empty;
    lsu_outs_cnt = cnt_q;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry payload is qualified by the count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) ent_mem_q[wr_ptr_q] <= ent_d;
  end

endmodule
